// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
// Serves MULT/MULTU/DIV/DIVU (multi-cycle) and MTHI/MTLO (single write in IDLE);
// MFHI/MFLO read hi/lo directly.
//
// Ports:
//   clock        rising-edge system clock
//   reset        asynchronous, active-high reset
//   start        launch an operation (sampled only in IDLE)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rA, rB       multiplicand/multiplier or dividend/divisor
//   flush        cancel the in-flight operation
//   hi_we, lo_we MTHI/MTLO write enables (honoured only in IDLE)
//   wdata        MTHI/MTLO write data
//   busy         operation in flight
//   done         one-cycle pulse when an operation has written hi/lo
//   hi, lo       HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rA,
    input  logic [WIDTH-1:0] rB,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d;      // sign of rA (signed ops only)
    logic               sb_q, sb_d;      // sign of rB (signed ops only)
    logic [WIDTH-1:0]   b_q, b_d;        // magnitude of rB
    logic [2*WIDTH-1:0] acc_q, acc_d;    // {upper, lower}: product, or {remainder, dividend/quotient}
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand conditioning at launch
    logic             a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg_in = ~op[0] & rA[WIDTH-1];
    assign b_neg_in = ~op[0] & rB[WIDTH-1];
    assign a_mag    = a_neg_in ? (~rA + WIDTH'(1)) : rA;
    assign b_mag    = b_neg_in ? (~rB + WIDTH'(1)) : rB;

    // Shift-add step: low bit of the multiplier half selects the add, then the
    // whole accumulator shifts right with the carry entering at the top.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_mul;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign acc_mul = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder, trial
    // subtract, keep the difference when it does not borrow.
    logic [WIDTH:0]     rem_sh, diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] acc_div;

    assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff    = rem_sh - {1'b0, b_q};
    assign q_bit   = ~diff[WIDTH];
    assign rem_new = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign acc_div = {rem_new, acc_q[WIDTH-2:0], q_bit};

    // Sign correction of the final results
    logic               res_neg, rem_neg;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quot_c, rem_c;

    assign res_neg = ~op_q[0] & (sa_q ^ sb_q);
    assign rem_neg = ~op_q[0] & sa_q;
    assign prod_c  = res_neg ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    assign quot_c  = res_neg ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    // Divide by zero leaves the dividend magnitude in the remainder half, so the
    // sign-corrected remainder is already rA as latched.
    assign rem_c   = rem_neg ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && !flush) begin
                    op_d    = op;
                    sa_d    = a_neg_in;
                    sb_d    = b_neg_in;
                    b_d     = b_mag;
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = op_q[1] ? acc_div : acc_mul;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        lo_d = (b_q == '0) ? '1 : quot_c;
                        hi_d = rem_c;
                    end else begin
                        hi_d = prod_c[2*WIDTH-1:WIDTH];
                        lo_d = prod_c[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH=32). Expected
// results come from plain 64-bit / signed-int arithmetic.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op    = '0;
    logic [W-1:0] rA    = '0;
    logic [W-1:0] rB    = '0;
    logic         flush = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .rA    (rA),
        .rB    (rB),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        longint      pa, pb;
        logic [63:0] p;
        int          ia, ib;
        eh = '0;
        el = '0;
        case (o)
            2'd0: begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
                p  = 64'(pa * pb);
                eh = p[63:32];
                el = p[31:0];
            end
            2'd1: begin
                p  = {32'b0, a} * {32'b0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (b == 0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else if (o == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000;
                    eh = 32'h0;
                end else if (o == 2'd2) begin
                    ia = $signed(a);
                    ib = $signed(b);
                    el = 32'(ia / ib);
                    eh = 32'(ia % ib);
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    // Waits from the cycle after the start edge until done, checking latency,
    // busy duration and results.
    task automatic finish_op(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
        int c = 0;
        int busy_cnt = 0;
        while (done !== 1'b1 && c < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clock);
            c++;
        end
        check({tag, " latency"}, 64'(c), 64'(W + 1));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(W + 1));
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        m_hi = eh;
        m_lo = el;
        @(negedge clock);
        check({tag, " done pulse width"}, 64'(done), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        model(o, a, b, eh, el);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        rA    = a;
        rB    = b;
        @(negedge clock);
        start = 1'b0;
        finish_op(tag, eh, el);
    endtask

    function automatic logic [W-1:0] pick(input bit allow_zero);
        int unsigned sel = $urandom_range(0, 9);
        case (sel)
            0:       return allow_zero ? 32'h0 : 32'h1;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] cap_hi, cap_lo, ra_v, rb_v;
        logic [1:0]   o_v;
        int           dones, done_at;

        // Reset state
        #12;
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        @(negedge clock);
        reset = 1'b0;

        // MTHI in IDLE
        @(negedge clock);
        hi_we = 1'b1;
        wdata = 32'h1234;
        @(negedge clock);
        hi_we = 1'b0;
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi lo untouched", 64'(lo), 64'(0));
        m_hi = 32'h1234;

        // Directed arithmetic cases
        run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult -3*5", 2'd0, 32'hFFFF_FFFD, 32'd5);
        run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("divu 7/0", 2'd3, 32'd7, 32'd0);
        run_op("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div -9/0", 2'd2, 32'hFFFF_FFF7, 32'd0);
        run_op("div 7/-2", 2'd2, 32'd7, 32'hFFFF_FFFE);

        // Writes and starts while busy are ignored
        @(negedge clock);
        start = 1'b1;
        op    = 2'd1;
        rA    = 32'd3;
        rB    = 32'd4;
        @(negedge clock);
        start   = 1'b0;
        dones   = 0;
        done_at = -1;
        cap_hi  = '0;
        cap_lo  = '0;
        wdata   = 32'h5555;
        for (int c = 0; c < W + 8; c++) begin
            if (done === 1'b1) begin
                dones++;
                done_at = c;
                cap_hi  = hi;
                cap_lo  = lo;
            end
            if (c == 6) check("busy mtlo ignored", 64'(lo), 64'(m_lo));
            lo_we = (c == 5);
            start = (c == 10);
            if (c == 10) begin
                op = 2'd3;
                rA = 32'd100;
                rB = 32'd5;
            end
            @(negedge clock);
        end
        lo_we = 1'b0;
        start = 1'b0;
        check("busy ignore done count", 64'(dones), 64'(1));
        check("busy ignore latency", 64'(done_at), 64'(W + 1));
        check("busy ignore hi", 64'(cap_hi), 64'(0));
        check("busy ignore lo", 64'(cap_lo), 64'(12));
        m_hi = 32'd0;
        m_lo = 32'd12;

        // Flush mid-operation
        @(negedge clock);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hA;
        @(negedge clock);
        hi_we = 1'b0;
        wdata = 32'hB;
        @(negedge clock);
        lo_we = 1'b0;
        m_hi  = 32'hA;
        m_lo  = 32'hB;
        start = 1'b1;
        op    = 2'd3;
        rA    = 32'd100;
        rB    = 32'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'(0));
        check("flush done", 64'(done), 64'(0));
        check("flush hi", 64'(hi), 64'hA);
        check("flush lo", 64'(lo), 64'hB);
        @(negedge clock);
        check("flush no late done", 64'(done), 64'(0));
        run_op("after flush divu", 2'd3, 32'd100, 32'd7);

        // Flush with start in IDLE: start ignored
        @(negedge clock);
        start = 1'b1;
        flush = 1'b1;
        op    = 2'd1;
        rA    = 32'd5;
        rB    = 32'd5;
        @(negedge clock);
        start = 1'b0;
        flush = 1'b0;
        check("idle flush+start busy", 64'(busy), 64'(0));
        @(negedge clock);
        check("idle flush+start done", 64'(done), 64'(0));
        check("idle flush+start lo", 64'(lo), 64'(m_lo));

        // Write coinciding with start: write lands, result overwrites later
        @(negedge clock);
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'hDEAD;
        op    = 2'd1;
        rA    = 32'd2;
        rB    = 32'd9;
        @(negedge clock);
        start = 1'b0;
        hi_we = 1'b0;
        check("write+start hi", 64'(hi), 64'hDEAD);
        finish_op("write+start op", 32'd0, 32'd18);

        // Randomised operations
        for (int i = 0; i < 24; i++) begin
            o_v  = 2'($urandom_range(0, 3));
            ra_v = pick(1'b1);
            rb_v = pick(o_v[1] ? ($urandom_range(0, 5) == 0) : 1'b1);
            run_op($sformatf("rand%0d op%0d", i, o_v), o_v, ra_v, rb_v);
        end

        // Asynchronous reset mid-operation
        @(negedge clock);
        start = 1'b1;
        op    = 2'd0;
        rA    = 32'($urandom);
        rB    = 32'($urandom);
        @(negedge clock);
        start = 1'b0;
        repeat (15) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async reset busy", 64'(busy), 64'(0));
        check("async reset done", 64'(done), 64'(0));
        check("async reset hi", 64'(hi), 64'(0));
        check("async reset lo", 64'(lo), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        run_op("post reset multu", 2'd1, 32'd2, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
